// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write path: geometry, address
// packing, the write-port payload and the fill-engine state encoding.
package fb_pkg;

    localparam int unsigned FB_COLS = 80;
    localparam int unsigned FB_ROWS = 60;
    localparam int unsigned FB_XW   = 7;
    localparam int unsigned FB_YW   = 6;
    localparam int unsigned FB_AW   = 13;
    localparam int unsigned FB_DW   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // One framebuffer write-port beat.
    typedef struct packed {
        logic             we;
        logic [FB_AW-1:0] wa;
        logic [FB_DW-1:0] wd;
    } fb_wr_t;

    // Pixel address layout is {y, x}.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [FB_XW-1:0] x,
                                                 input logic [FB_YW-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// Raster x/y counter for the rectangle fill engine.
// Ports: CLK/RST clock and async active-high reset; load captures origin and
// clipped end corner; en advances one pixel (x fastest); x/y current pixel;
// last_c is high while the current pixel is the bottom-right corner.
import fb_pkg::*;

module rect_scan_counter (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             en,
    input  logic [FB_XW-1:0] x0,
    input  logic [FB_YW-1:0] y0,
    input  logic [FB_XW-1:0] x_end,
    input  logic [FB_YW-1:0] y_end,
    output logic [FB_XW-1:0] x,
    output logic [FB_YW-1:0] y,
    output logic             last_c
);

    logic [FB_XW-1:0] x0_q;
    logic [FB_XW-1:0] x_end_q;
    logic [FB_YW-1:0] y_end_q;

    // Bounds are captured at load so later parameter changes cannot disturb a running fill.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x       <= '0;
            y       <= '0;
            x0_q    <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
        end else if (load) begin
            x       <= x0;
            y       <= y0;
            x0_q    <= x0;
            x_end_q <= x_end;
            y_end_q <= y_end;
        end else if (en) begin
            if (x == x_end_q) begin
                x <= x0_q;
                y <= y + FB_YW'(1);
            end else begin
                x <= x + FB_XW'(1);
            end
        end
    end

    assign last_c = (x == x_end_q) && (y == y_end_q);

endmodule

// File: rtl/fb_fill_arbiter.sv
// Framebuffer write-port owner: merges CPU MMIO pixel writes with a
// rectangle-fill engine, CPU having fixed priority.
// Ports: CLK/RST; CPU_WE/WA/WD single-pixel CPU write; FILL_START with
// FILL_X0/Y0/W/H/COLOR rectangle request; FB_WE/WA/WD registered framebuffer
// write port; FILL_BUSY fill in progress; FILL_DONE one-cycle completion pulse.
import fb_pkg::*;

module fb_fill_arbiter #(
    parameter int unsigned COLS = FB_COLS,
    parameter int unsigned ROWS = FB_ROWS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CPU_WE,
    input  logic [FB_AW-1:0] CPU_WA,
    input  logic [FB_DW-1:0] CPU_WD,
    input  logic             FILL_START,
    input  logic [FB_XW-1:0] FILL_X0,
    input  logic [FB_YW-1:0] FILL_Y0,
    input  logic [FB_XW-1:0] FILL_W,
    input  logic [FB_YW-1:0] FILL_H,
    input  logic [FB_DW-1:0] FILL_COLOR,
    output logic             FB_WE,
    output logic [FB_AW-1:0] FB_WA,
    output logic [FB_DW-1:0] FB_WD,
    output logic             FILL_BUSY,
    output logic             FILL_DONE
);

    localparam logic [FB_XW:0] X_LAST = (FB_XW+1)'(COLS - 1);
    localparam logic [FB_YW:0] Y_LAST = (FB_YW+1)'(ROWS - 1);

    fill_state_t      state_q, state_d;
    fb_wr_t           wr_q, wr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [FB_DW-1:0] color_q;

    logic [FB_XW:0]   x_sum_c;
    logic [FB_YW:0]   y_sum_c;
    logic [FB_XW-1:0] x_end_c;
    logic [FB_YW-1:0] y_end_c;
    logic             empty_c;
    logic             load_c;
    logic             step_c;
    logic             last_c;
    logic [FB_XW-1:0] scan_x;
    logic [FB_YW-1:0] scan_y;

    // Clipped end corner and empty-rectangle detection for a new request.
    always_comb begin
        x_sum_c = {1'b0, FILL_X0} + {1'b0, FILL_W} - (FB_XW+1)'(1);
        y_sum_c = {1'b0, FILL_Y0} + {1'b0, FILL_H} - (FB_YW+1)'(1);
        x_end_c = (x_sum_c > X_LAST) ? X_LAST[FB_XW-1:0] : x_sum_c[FB_XW-1:0];
        y_end_c = (y_sum_c > Y_LAST) ? Y_LAST[FB_YW-1:0] : y_sum_c[FB_YW-1:0];
        empty_c = (FILL_W == FB_XW'(0)) || (FILL_H == FB_YW'(0)) ||
                  ({1'b0, FILL_X0} > X_LAST) || ({1'b0, FILL_Y0} > Y_LAST);
    end

    rect_scan_counter u_scan (
        .CLK    (CLK),
        .RST    (RST),
        .load   (load_c),
        .en     (step_c),
        .x0     (FILL_X0),
        .y0     (FILL_Y0),
        .x_end  (x_end_c),
        .y_end  (y_end_c),
        .x      (scan_x),
        .y      (scan_y),
        .last_c (last_c)
    );

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            wr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (load_c) begin
                color_q <= FILL_COLOR;
            end
        end
    end

    // Next state, arbitration mux and counter control; a CPU write stalls the scan.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        wr_d.we  = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load_c   = 1'b0;
        step_c   = 1'b0;

        if (CPU_WE) begin
            wr_d.we = 1'b1;
            wr_d.wa = CPU_WA;
            wr_d.wd = CPU_WD;
        end

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (FILL_START) begin
                    if (empty_c) begin
                        done_d = 1'b1;
                    end else begin
                        load_c  = 1'b1;
                        busy_d  = 1'b1;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                busy_d = 1'b1;
                if (!CPU_WE) begin
                    wr_d.we = 1'b1;
                    wr_d.wa = fb_addr(scan_x, scan_y);
                    wr_d.wd = color_q;
                    step_c  = 1'b1;
                    if (last_c) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign FB_WE     = wr_q.we;
    assign FB_WA     = wr_q.wa;
    assign FB_WD     = wr_q.wd;
    assign FILL_BUSY = busy_q;
    assign FILL_DONE = done_q;

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// Self-checking bench for fb_fill_arbiter: single-cycle vector table,
// directed multi-cycle sequences and random traffic against a queue model.
module tb_fb_fill_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CPU_WE;
    logic [12:0] CPU_WA;
    logic [7:0]  CPU_WD;
    logic        FILL_START;
    logic [6:0]  FILL_X0;
    logic [5:0]  FILL_Y0;
    logic [6:0]  FILL_W;
    logic [5:0]  FILL_H;
    logic [7:0]  FILL_COLOR;
    logic        FB_WE;
    logic [12:0] FB_WA;
    logic [7:0]  FB_WD;
    logic        FILL_BUSY;
    logic        FILL_DONE;

    always #5 CLK = ~CLK;

    fb_fill_arbiter #(.COLS(80), .ROWS(60)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_WE(CPU_WE), .CPU_WA(CPU_WA), .CPU_WD(CPU_WD),
        .FILL_START(FILL_START), .FILL_X0(FILL_X0), .FILL_Y0(FILL_Y0),
        .FILL_W(FILL_W), .FILL_H(FILL_H), .FILL_COLOR(FILL_COLOR),
        .FB_WE(FB_WE), .FB_WA(FB_WA), .FB_WD(FB_WD),
        .FILL_BUSY(FILL_BUSY), .FILL_DONE(FILL_DONE)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending pixels of the running fill as a plain queue.
    logic [12:0] m_q[$];
    logic [7:0]  m_col;
    logic        m_we, m_busy, m_done;
    logic [12:0] m_wa;
    logic [7:0]  m_wd;

    task automatic model_clear();
        m_q.delete();
        m_col = '0; m_we = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_wa = '0; m_wd = '0;
    endtask

    task automatic model_step(input logic we, input logic [12:0] wa, input logic [7:0] wd,
                              input logic st, input logic [6:0] x0, input logic [5:0] y0,
                              input logic [6:0] w, input logic [5:0] h, input logic [7:0] col);
        int xe, ye;
        m_we   = 1'b0;
        m_done = 1'b0;
        if (we) begin
            m_we = 1'b1; m_wa = wa; m_wd = wd;
        end
        if (m_q.size() == 0) begin
            if (st) begin
                xe = int'(x0) + int'(w) - 1;
                ye = int'(y0) + int'(h) - 1;
                if (xe > 79) xe = 79;
                if (ye > 59) ye = 59;
                for (int yy = int'(y0); yy <= ye; yy++)
                    for (int xx = int'(x0); xx <= xe; xx++)
                        m_q.push_back({yy[5:0], xx[6:0]});
                if (m_q.size() == 0) m_done = 1'b1;
                else m_col = col;
            end
        end else if (!we) begin
            m_we = 1'b1;
            m_wa = m_q.pop_front();
            m_wd = m_col;
            if (m_q.size() == 0) m_done = 1'b1;
        end
        m_busy = (m_q.size() != 0);
    endtask

    task automatic drive(input logic we, input logic [12:0] wa, input logic [7:0] wd,
                         input logic st, input logic [6:0] x0, input logic [5:0] y0,
                         input logic [6:0] w, input logic [5:0] h, input logic [7:0] col);
        CPU_WE = we; CPU_WA = wa; CPU_WD = wd; FILL_START = st;
        FILL_X0 = x0; FILL_Y0 = y0; FILL_W = w; FILL_H = h; FILL_COLOR = col;
    endtask

    // One model-checked clock cycle.
    task automatic cyc(input logic we, input logic [12:0] wa, input logic [7:0] wd,
                       input logic st, input logic [6:0] x0, input logic [5:0] y0,
                       input logic [6:0] w, input logic [5:0] h, input logic [7:0] col);
        drive(we, wa, wd, st, x0, y0, w, h, col);
        model_step(we, wa, wd, st, x0, y0, w, h, col);
        @(posedge CLK); #1;
        chk("fb_we",     32'(FB_WE),     32'(m_we));
        chk("fb_wa",     32'(FB_WA),     32'(m_wa));
        chk("fb_wd",     32'(FB_WD),     32'(m_wd));
        chk("fill_busy", 32'(FILL_BUSY), 32'(m_busy));
        chk("fill_done", 32'(FILL_DONE), 32'(m_done));
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    task automatic start(input logic [6:0] x0, input logic [5:0] y0,
                         input logic [6:0] w, input logic [5:0] h, input logic [7:0] col);
        cyc(1'b0, '0, '0, 1'b1, x0, y0, w, h, col);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0);
        RST = 1'b1;
        #1;
        chk("rst_we",   32'(FB_WE),     32'd0);
        chk("rst_wa",   32'(FB_WA),     32'd0);
        chk("rst_wd",   32'(FB_WD),     32'd0);
        chk("rst_busy", 32'(FILL_BUSY), 32'd0);
        chk("rst_done", 32'(FILL_DONE), 32'd0);
        model_clear();
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [12:0] wa;
        logic [7:0]  wd;
        logic        st;
        logic [6:0]  x0;
        logic [5:0]  y0;
        logic [6:0]  w;
        logic [5:0]  h;
        logic [7:0]  col;
        logic        e_we;
        logic [12:0] e_wa;
        logic [7:0]  e_wd;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t        tv[9];
    logic [12:0] basic_exp[6];
    logic [12:0] obs;
    int          cnt, done_at;

    initial begin
        // Outputs one edge after each vector is applied from IDLE.
        tv[0] = '{1'b1, 13'h0105, 8'h1C, 1'b0, 7'd0,   6'd0,  7'd0,  6'd0, 8'h00, 1'b1, 13'h0105, 8'h1C, 1'b0, 1'b0};
        tv[1] = '{1'b0, 13'h0000, 8'h00, 1'b1, 7'd4,   6'd4,  7'd0,  6'd3, 8'h11, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b1};
        tv[2] = '{1'b0, 13'h0000, 8'h00, 1'b1, 7'd4,   6'd4,  7'd3,  6'd0, 8'h11, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b1};
        tv[3] = '{1'b0, 13'h0000, 8'h00, 1'b1, 7'd80,  6'd0,  7'd5,  6'd5, 8'h22, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b1};
        tv[4] = '{1'b0, 13'h0000, 8'h00, 1'b1, 7'd0,   6'd60, 7'd5,  6'd5, 8'h22, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b1};
        tv[5] = '{1'b1, 13'h0ABC, 8'h55, 1'b1, 7'd127, 6'd0,  7'd5,  6'd5, 8'h33, 1'b1, 13'h0ABC, 8'h55, 1'b0, 1'b1};
        tv[6] = '{1'b0, 13'h0000, 8'h00, 1'b1, 7'd2,   6'd3,  7'd3,  6'd2, 8'hE0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b0};
        tv[7] = '{1'b1, 13'h1234, 8'hAA, 1'b1, 7'd10,  6'd10, 7'd2,  6'd2, 8'h44, 1'b1, 13'h1234, 8'hAA, 1'b1, 1'b0};
        tv[8] = '{1'b0, 13'h0000, 8'h00, 1'b1, 7'd79,  6'd59, 7'd1,  6'd1, 8'h66, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b0};
        basic_exp[0] = 13'h182; basic_exp[1] = 13'h183; basic_exp[2] = 13'h184;
        basic_exp[3] = 13'h202; basic_exp[4] = 13'h203; basic_exp[5] = 13'h204;

        RST = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0);
        do_reset();

        // Table vectors; any fill that starts is drained before the next vector.
        for (int i = 0; i < 9; i++) begin
            drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].st, tv[i].x0, tv[i].y0, tv[i].w, tv[i].h, tv[i].col);
            @(posedge CLK); #1;
            chk($sformatf("tv%0d_we", i),   32'(FB_WE),     32'(tv[i].e_we));
            chk($sformatf("tv%0d_busy", i), 32'(FILL_BUSY), 32'(tv[i].e_busy));
            chk($sformatf("tv%0d_done", i), 32'(FILL_DONE), 32'(tv[i].e_done));
            if (tv[i].e_we) begin
                chk($sformatf("tv%0d_wa", i), 32'(FB_WA), 32'(tv[i].e_wa));
                chk($sformatf("tv%0d_wd", i), 32'(FB_WD), 32'(tv[i].e_wd));
            end
            drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0);
            for (int k = 0; k < 6000 && FILL_BUSY; k++) begin
                @(posedge CLK); #1;
            end
            chk($sformatf("tv%0d_drained", i), 32'(FILL_BUSY), 32'd0);
        end
        do_reset();

        // Basic fill: six raster-order writes, DONE with the sixth, BUSY for six cycles.
        start(7'd2, 6'd3, 7'd3, 6'd2, 8'hE0);
        cnt = FILL_BUSY ? 1 : 0;
        done_at = -1;
        for (int i = 1; i <= 7; i++) begin
            idle();
            if (i <= 6) begin
                obs = FB_WA;
                chk($sformatf("basic_px%0d", i), 32'(obs), 32'(basic_exp[i-1]));
                chk($sformatf("basic_col%0d", i), 32'(FB_WD), 32'hE0);
            end
            if (FILL_BUSY) cnt++;
            if (FILL_DONE) done_at = i;
        end
        chk("basic_busy_cycles", 32'(cnt), 32'd6);
        chk("basic_done_edge", 32'(done_at), 32'd6);

        // Clipping at the bottom-right corner: only (78,59) and (79,59).
        start(7'd78, 6'd59, 7'd5, 6'd4, 8'h77);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (FB_WE) cnt++;
        end
        chk("clip_writes", 32'(cnt), 32'd2);

        // CPU priority: CPU write on pixel 4's edge delays the fill by one cycle.
        start(7'd5, 6'd7, 7'd10, 6'd1, 8'h3C);
        done_at = -1;
        for (int i = 1; i <= 13; i++) begin
            if (i == 4) cyc(1'b1, 13'h0105, 8'h1C, 1'b0, '0, '0, '0, '0, '0);
            else idle();
            if (i == 4) begin
                chk("prio_cpu_wa", 32'(FB_WA), 32'h0105);
                chk("prio_cpu_wd", 32'(FB_WD), 32'h1C);
            end
            if (i == 5) chk("prio_px4_wa", 32'(FB_WA), 32'h388);
            if (FILL_DONE) done_at = i;
        end
        chk("prio_done_edge", 32'(done_at), 32'd11);

        // Restart while busy is ignored; one DONE only.
        start(7'd10, 6'd10, 7'd3, 6'd2, 8'h5A);
        cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) start(7'd0, 6'd0, 7'd20, 6'd20, 8'hA5);
            else idle();
            if (FILL_DONE) cnt++;
        end
        chk("restart_done_count", 32'(cnt), 32'd1);

        // Reset during pixel 5 of a 20-pixel fill, then a fresh fill.
        start(7'd0, 6'd20, 7'd20, 6'd1, 8'h99);
        for (int i = 1; i <= 4; i++) idle();
        #2;
        do_reset();
        for (int i = 0; i < 5; i++) idle();
        start(7'd40, 6'd40, 7'd4, 6'd2, 8'h12);
        for (int i = 0; i < 10; i++) idle();

        // Full-screen fill, clipped from 127x63 to 80x60.
        start(7'd0, 6'd0, 7'd127, 6'd63, 8'hFF);
        for (int i = 0; i < 4802; i++) idle();

        // Random mix of CPU writes and fill requests.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) == 0, 13'($urandom), 8'($urandom),
                $urandom_range(0, 15) == 0, 7'($urandom_range(0, 90)), 6'($urandom_range(0, 65)),
                7'($urandom_range(0, 12)), 6'($urandom_range(0, 4)), 8'($urandom));
        end
        for (int i = 0; i < 200; i++) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
